mem_port_arbiter: RTL and testbench

//  Shares one pipelined-Wishbone memory port between a core's instruction port (imem) and data port (dmem).

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter_lane_align.sv | 25 ++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and width encodings for the imem/dmem Wishbone port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  typedef enum logic {IMEM, DMEM} port_t;

  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;

  // Unshifted byte-enable pattern for an access width; illegal width gets none.
  function automatic logic [3:0] laneMask(input logic [1:0] width);
    case (width)
      WIDTH_B: laneMask = 4'b0001;
      WIDTH_H: laneMask = 4'b0011;
      WIDTH_W: laneMask = 4'b1111;
      default: laneMask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response ports and Wishbone master bus shared by the arbiter.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_resp;
  logic [31:0]       imem_rdata;
  logic              imem_err;

  logic              dmem_req;
  logic              dmem_cmd;
  logic [1:0]        dmem_width;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  logic              dmem_err;

  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [3:0]        wb_sel;
  logic [ADDR_W-1:0] wb_addr;
  logic [31:0]       wb_dat_o;
  logic [31:0]       wb_dat_i;
  logic              wb_ack;

  modport master (
    input  imem_req, imem_addr,
    output imem_resp, imem_rdata, imem_err,
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_resp, dmem_err,
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dat_o,
    input  wb_dat_i, wb_ack
  );

  modport slave (
    output imem_req, imem_addr,
    input  imem_resp, imem_rdata, imem_err,
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_resp, dmem_err,
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dat_o,
    output wb_dat_i, wb_ack
  );

endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane generation for data accesses: enables, lane-shifted store data, alignment check.
module wb_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_width,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_data,
  output logic        o_misaligned
);

  always_comb begin
    o_sel        = laneMask(i_width) << i_off;
    o_data       = i_wdata << {i_off, 3'b000};
    o_misaligned = 1'b1;
    case (i_width)
      WIDTH_B: o_misaligned = 1'b0;
      WIDTH_H: o_misaligned = i_off[0];
      WIDTH_W: o_misaligned = |i_off;
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one Wishbone port between instruction and data requesters,
// one transaction in flight, with ack timeout and error return for illegal data accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
)(
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.master bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  state_t            r_state, w_state;
  port_t             r_lastGrant, w_lastGrant;
  port_t             r_grant, w_grant;
  logic [TW-1:0]     r_timer, w_timer;
  logic              r_wbCyc, w_wbCyc, r_wbStb, w_wbStb, r_wbWe, w_wbWe;
  logic [3:0]        r_wbSel, w_wbSel;
  logic [ADDR_W-1:0] r_wbAddr, w_wbAddr;
  logic [31:0]       r_wbDatO, w_wbDatO;
  logic              r_imemResp, w_imemResp, r_dmemResp, w_dmemResp;
  logic [31:0]       r_rdata, w_rdata;
  logic              r_err, w_err;

  logic [3:0]  w_laneSel;
  logic [31:0] w_laneData;
  logic        w_misaligned;
  logic        w_pickImem, w_pickDmem;

  wb_lane_align u_align (
    .i_off        (bus.dmem_addr[1:0]),
    .i_width      (bus.dmem_width),
    .i_wdata      (bus.dmem_wdata),
    .o_sel        (w_laneSel),
    .o_data       (w_laneData),
    .o_misaligned (w_misaligned)
  );

  // On a tie the port that did not win last time goes first.
  assign w_pickImem = bus.imem_req && (!bus.dmem_req || r_lastGrant == DMEM);
  assign w_pickDmem = bus.dmem_req && !w_pickImem;

  always_comb begin
    w_state     = r_state;
    w_lastGrant = r_lastGrant;
    w_grant     = r_grant;
    w_timer     = r_timer;
    w_wbCyc     = r_wbCyc;
    w_wbStb     = 1'b0;
    w_wbWe      = r_wbWe;
    w_wbSel     = r_wbSel;
    w_wbAddr    = r_wbAddr;
    w_wbDatO    = r_wbDatO;
    w_imemResp  = 1'b0;
    w_dmemResp  = 1'b0;
    w_rdata     = r_rdata;
    w_err       = r_err;
    case (r_state)
      IDLE: begin
        w_timer = '0;
        if (w_pickImem) begin
          w_lastGrant = IMEM;
          w_grant     = IMEM;
          w_state     = BUS;
          w_wbCyc     = 1'b1;
          w_wbStb     = 1'b1;
          w_wbWe      = 1'b0;
          w_wbSel     = 4'b1111;
          w_wbAddr    = bus.imem_addr & ~ADDR_W'(3);
          w_wbDatO    = '0;
        end else if (w_pickDmem) begin
          w_lastGrant = DMEM;
          w_grant     = DMEM;
          // Illegal data accesses never reach the bus and answer at once with an error.
          if (w_misaligned) begin
            w_state    = RESP;
            w_dmemResp = 1'b1;
            w_rdata    = '0;
            w_err      = 1'b1;
          end else begin
            w_state  = BUS;
            w_wbCyc  = 1'b1;
            w_wbStb  = 1'b1;
            w_wbWe   = bus.dmem_cmd;
            w_wbSel  = w_laneSel;
            w_wbAddr = bus.dmem_addr & ~ADDR_W'(3);
            w_wbDatO = w_laneData;
          end
        end
      end
      BUS: begin
        if (bus.wb_ack) begin
          w_state    = RESP;
          w_wbCyc    = 1'b0;
          w_wbWe     = 1'b0;
          w_imemResp = (r_grant == IMEM);
          w_dmemResp = (r_grant == DMEM);
          w_rdata    = bus.wb_dat_i;
          w_err      = 1'b0;
        end else if (TIMEOUT_CYCLES > 0 && r_timer == TLAST) begin
          w_state    = RESP;
          w_wbCyc    = 1'b0;
          w_wbWe     = 1'b0;
          w_imemResp = (r_grant == IMEM);
          w_dmemResp = (r_grant == DMEM);
          w_rdata    = '0;
          w_err      = 1'b1;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      RESP: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
        w_wbCyc = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lastGrant <= DMEM;
      r_grant     <= IMEM;
      r_timer     <= '0;
      r_wbCyc     <= 1'b0;
      r_wbStb     <= 1'b0;
      r_wbWe      <= 1'b0;
      r_wbSel     <= '0;
      r_wbAddr    <= '0;
      r_wbDatO    <= '0;
      r_imemResp  <= 1'b0;
      r_dmemResp  <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_lastGrant <= w_lastGrant;
      r_grant     <= w_grant;
      r_timer     <= w_timer;
      r_wbCyc     <= w_wbCyc;
      r_wbStb     <= w_wbStb;
      r_wbWe      <= w_wbWe;
      r_wbSel     <= w_wbSel;
      r_wbAddr    <= w_wbAddr;
      r_wbDatO    <= w_wbDatO;
      r_imemResp  <= w_imemResp;
      r_dmemResp  <= w_dmemResp;
      r_rdata     <= w_rdata;
      r_err       <= w_err;
    end
  end

  assign bus.wb_cyc     = r_wbCyc;
  assign bus.wb_stb     = r_wbStb;
  assign bus.wb_we      = r_wbWe;
  assign bus.wb_sel     = r_wbSel;
  assign bus.wb_addr    = r_wbAddr;
  assign bus.wb_dat_o   = r_wbDatO;
  assign bus.imem_resp  = r_imemResp;
  assign bus.imem_rdata = r_rdata;
  assign bus.imem_err   = r_err;
  assign bus.dmem_resp  = r_dmemResp;
  assign bus.dmem_rdata = r_rdata;
  assign bus.dmem_err   = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a lane/grant reference model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testCount = 0;
  int   failCount = 0;
  bit   modelLastD;

  mem_port_arbiter_if #(.ADDR_W(32)) bus();

  mem_port_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic dReq,
                               input logic dCmd, input logic [1:0] dWidth,
                               input logic [31:0] dAddr, input logic [31:0] dWdata);
    bus.imem_req   = iReq;
    bus.imem_addr  = iAddr;
    bus.dmem_req   = dReq;
    bus.dmem_cmd   = dCmd;
    bus.dmem_width = dWidth;
    bus.dmem_addr  = dAddr;
    bus.dmem_wdata = dWdata;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);
    bus.wb_ack   = 1'b0;
    bus.wb_dat_i = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    modelLastD = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".cyc"},   32'(bus.wb_cyc), 0);
    checkOutput({tag, ".stb"},   32'(bus.wb_stb), 0);
    checkOutput({tag, ".we"},    32'(bus.wb_we), 0);
    checkOutput({tag, ".sel"},   32'(bus.wb_sel), 0);
    checkOutput({tag, ".addr"},  bus.wb_addr, 0);
    checkOutput({tag, ".dato"},  bus.wb_dat_o, 0);
    checkOutput({tag, ".iresp"}, 32'(bus.imem_resp), 0);
    checkOutput({tag, ".dresp"}, 32'(bus.dmem_resp), 0);
    checkOutput({tag, ".rdata"}, bus.imem_rdata | bus.dmem_rdata, 0);
    checkOutput({tag, ".err"},   32'(bus.imem_err | bus.dmem_err), 0);
  endtask

  // Expected byte enables and lane data derived from access size in bytes and offset.
  function automatic void modelLanes(input logic [1:0] width, input logic [31:0] addr,
                                     input logic [31:0] wdata, output logic [3:0] sel,
                                     output logic [31:0] dat, output bit illegal);
    int nb;
    int off;
    off     = int'(addr % 4);
    nb      = (width == 2'd3) ? 0 : (1 << width);
    illegal = (nb == 0) || ((off % nb) != 0);
    sel     = illegal ? 4'b0000 : 4'(((1 << nb) - 1) << off);
    dat     = wdata << (8 * off);
  endfunction

  // Called in the request cycle; returns in the response cycle.
  task automatic serveBus(input string tag, input bit expD, input logic [31:0] expAddr,
                          input logic [3:0] expSel, input logic expWe, input bit chkDat,
                          input logic [31:0] expDat, input int ackDelay,
                          input logic [31:0] ackData);
    tick();
    checkOutput({tag, ".cyc"},  32'(bus.wb_cyc), 1);
    checkOutput({tag, ".stb"},  32'(bus.wb_stb), 1);
    checkOutput({tag, ".addr"}, bus.wb_addr, expAddr);
    checkOutput({tag, ".sel"},  32'(bus.wb_sel), 32'(expSel));
    checkOutput({tag, ".we"},   32'(bus.wb_we), 32'(expWe));
    if (chkDat) checkOutput({tag, ".dato"}, bus.wb_dat_o, expDat);
    for (int i = 0; i < ackDelay; i++) begin
      tick();
      checkOutput({tag, ".waitstb"}, 32'(bus.wb_stb), 0);
      checkOutput({tag, ".waitsel"}, 32'(bus.wb_sel), 32'(expSel));
    end
    bus.wb_ack   = 1'b1;
    bus.wb_dat_i = ackData;
    tick();
    bus.wb_ack   = 1'b0;
    bus.wb_dat_i = '0;
    checkOutput({tag, ".iresp"}, 32'(bus.imem_resp), 32'(!expD));
    checkOutput({tag, ".dresp"}, 32'(bus.dmem_resp), 32'(expD));
    checkOutput({tag, ".rdata"}, expD ? bus.dmem_rdata : bus.imem_rdata, ackData);
    checkOutput({tag, ".err"},   32'(expD ? bus.dmem_err : bus.imem_err), 0);
    checkOutput({tag, ".cycoff"}, 32'(bus.wb_cyc), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit         iPend, dPend, grantD, illegal;
    logic [31:0] iAddr, dAddr, dWdata, expDat, ackData;
    logic [1:0]  dWidth;
    logic        dCmd;
    logic [3:0]  expSel;

    doReset();
    checkAllZero("reset");

    applyStimulus(1, 32'h104, 0, 0, 2'b00, 0, 0);
    serveBus("imem104", 0, 32'h104, 4'b1111, 0, 0, 0, 1, 32'hDEADBEEF);
    bus.imem_req = 1'b0;
    tick();
    checkOutput("imem104.pulse", 32'(bus.imem_resp), 0);

    doReset();
    applyStimulus(1, 32'h100, 1, 0, 2'b10, 32'h300, 32'h0);
    for (int n = 0; n < 4; n++) begin
      grantD = (n % 2) == 1;
      serveBus(grantD ? "rrD" : "rrI", grantD, grantD ? 32'h300 : 32'h100, 4'b1111, 0, 1'b0, 0,
               n % 3, 32'h1000 + 32'(n));
      tick();
      checkOutput("rr.noresp", 32'(bus.imem_resp | bus.dmem_resp), 0);
    end
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);
    tick();

    applyStimulus(0, 0, 1, 1, 2'b00, 32'h203, 32'hA5);
    serveBus("sb203", 1, 32'h200, 4'b1000, 1, 1, 32'hA500_0000, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);
    tick();

    applyStimulus(0, 0, 1, 0, 2'b10, 32'h202, 32'h0);
    tick();
    checkOutput("lw202.cyc",   32'(bus.wb_cyc | bus.wb_stb), 0);
    checkOutput("lw202.dresp", 32'(bus.dmem_resp), 1);
    checkOutput("lw202.err",   32'(bus.dmem_err), 1);
    checkOutput("lw202.rdata", bus.dmem_rdata, 0);
    checkOutput("lw202.iresp", 32'(bus.imem_resp), 0);
    bus.dmem_req = 1'b0;
    tick();
    checkOutput("lw202.after", 32'(bus.wb_cyc | bus.wb_stb | bus.dmem_resp), 0);

    applyStimulus(1, 32'h400, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("tmo.cyc", 32'(bus.wb_cyc), 1);
    end
    tick();
    checkOutput("tmo.iresp", 32'(bus.imem_resp), 1);
    checkOutput("tmo.err",   32'(bus.imem_err), 1);
    checkOutput("tmo.rdata", bus.imem_rdata, 0);
    checkOutput("tmo.cycoff", 32'(bus.wb_cyc), 0);
    bus.imem_req = 1'b0;
    bus.wb_ack   = 1'b1;
    bus.wb_dat_i = 32'h5555_AAAA;
    tick();
    checkOutput("tmo.late1", 32'(bus.imem_resp | bus.dmem_resp | bus.wb_cyc), 0);
    tick();
    checkOutput("tmo.late2", 32'(bus.imem_resp | bus.dmem_resp | bus.wb_cyc), 0);
    bus.wb_ack   = 1'b0;
    bus.wb_dat_i = '0;

    doReset();
    applyStimulus(1, 32'h80, 0, 0, 2'b00, 0, 0);
    tick();
    checkOutput("rstmid.stb", 32'(bus.wb_stb), 1);
    tick();
    checkOutput("rstmid.cyc2", 32'(bus.wb_cyc), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelLastD = 1'b1;
    checkAllZero("rstmid");
    serveBus("rstmid.again", 0, 32'h80, 4'b1111, 0, 0, 0, 1, 32'hCAFE_F00D);
    bus.imem_req = 1'b0;
    tick();

    doReset();
    iPend = 0;
    dPend = 0;
    for (int n = 0; n < 40; n++) begin
      if (!iPend && $urandom_range(0, 1) == 1) begin
        iPend = 1;
        iAddr = $urandom;
      end
      if (!dPend && $urandom_range(0, 1) == 1) begin
        dPend  = 1;
        dAddr  = $urandom;
        dWidth = 2'($urandom_range(0, 3));
        dCmd   = 1'($urandom_range(0, 1));
        dWdata = $urandom;
      end
      if (!iPend && !dPend) begin
        iPend = 1;
        iAddr = $urandom;
      end
      applyStimulus(iPend, iAddr, dPend, dCmd, dWidth, dAddr, dWdata);
      grantD     = dPend && (!iPend || !modelLastD);
      modelLastD = grantD;
      ackData    = $urandom;
      if (grantD) begin
        modelLanes(dWidth, dAddr, dWdata, expSel, expDat, illegal);
        if (illegal) begin
          tick();
          checkOutput("rnd.badcyc", 32'(bus.wb_cyc | bus.wb_stb), 0);
          checkOutput("rnd.baddresp", 32'(bus.dmem_resp), 1);
          checkOutput("rnd.badiresp", 32'(bus.imem_resp), 0);
          checkOutput("rnd.baderr", 32'(bus.dmem_err), 1);
          checkOutput("rnd.badrdata", bus.dmem_rdata, 0);
        end else begin
          serveBus("rndD", 1, {dAddr[31:2], 2'b00}, expSel, dCmd, 1, expDat,
                   $urandom_range(0, 2), ackData);
        end
        dPend = 0;
        bus.dmem_req = 1'b0;
      end else begin
        serveBus("rndI", 0, {iAddr[31:2], 2'b00}, 4'b1111, 0, 0, 0,
                 $urandom_range(0, 2), ackData);
        iPend = 0;
        bus.imem_req = 1'b0;
      end
      tick();
      checkOutput("rnd.idle", 32'(bus.imem_resp | bus.dmem_resp | bus.wb_cyc), 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
